// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-to-one AXI4-lite arbiter.
package axi_arb_pkg;

    // One transaction in flight at a time: address phase, then data/response phase.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4
    } arb_state_e;

    localparam logic       PORT_INST  = 1'b0;
    localparam logic       PORT_DATA  = 1'b1;
    localparam logic [1:0] BRESP_OKAY = 2'b00;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for two requesters.
// ROUND_ROBIN=1: on a tie the port that was not granted last (ptr_i) wins.
// ROUND_ROBIN=0: the data port always wins a tie.
module arb_pick
    import axi_arb_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic       win_o,
    output logic       win_valid_o
);

    assign win_valid_o = |req_i;

    generate
        if (ROUND_ROBIN) begin : g_rr
            // Tie goes to the port other than the last winner.
            always_comb begin
                if (req_i[PORT_INST] && req_i[PORT_DATA]) begin
                    win_o = ~ptr_i;
                end else begin
                    win_o = req_i[PORT_DATA] ? PORT_DATA : PORT_INST;
                end
            end
        end else begin : g_fixed
            logic unused_ptr;
            assign unused_ptr = ptr_i;
            assign win_o      = req_i[PORT_DATA] ? PORT_DATA : PORT_INST;
        end
    endgenerate

endmodule

// File: rtl/axi_lite_arbiter.sv
// Two-to-one AXI4-lite arbiter: s0 = instruction bridge, s1 = data bridge,
// m = the shared AXIMem. One transaction at a time, registered grant.
// A flush during an s0 read marks the read as dropped: the slave still
// completes it, the arbiter consumes the beat and hides it from s0.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority with s1 winning every tie.
module axi_lite_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    // upstream port 0 (instruction)
    input  logic                s0_ar_valid,
    output logic                s0_ar_ready,
    input  logic [ADDR_W-1:0]   s0_ar_addr,
    input  logic [2:0]          s0_ar_prot,
    input  logic                s0_aw_valid,
    output logic                s0_aw_ready,
    input  logic [ADDR_W-1:0]   s0_aw_addr,
    input  logic [2:0]          s0_aw_prot,
    input  logic                s0_wd_valid,
    output logic                s0_wd_ready,
    input  logic [DATA_W-1:0]   s0_wd_data,
    input  logic [DATA_W/8-1:0] s0_wstrb,
    output logic                s0_rd_valid,
    input  logic                s0_rd_ready,
    output logic [DATA_W-1:0]   s0_rd_data,
    output logic                s0_wr_valid,
    input  logic                s0_wr_ready,
    output logic [1:0]          s0_wr_breap,
    // upstream port 1 (data)
    input  logic                s1_ar_valid,
    output logic                s1_ar_ready,
    input  logic [ADDR_W-1:0]   s1_ar_addr,
    input  logic [2:0]          s1_ar_prot,
    input  logic                s1_aw_valid,
    output logic                s1_aw_ready,
    input  logic [ADDR_W-1:0]   s1_aw_addr,
    input  logic [2:0]          s1_aw_prot,
    input  logic                s1_wd_valid,
    output logic                s1_wd_ready,
    input  logic [DATA_W-1:0]   s1_wd_data,
    input  logic [DATA_W/8-1:0] s1_wstrb,
    output logic                s1_rd_valid,
    input  logic                s1_rd_ready,
    output logic [DATA_W-1:0]   s1_rd_data,
    output logic                s1_wr_valid,
    input  logic                s1_wr_ready,
    output logic [1:0]          s1_wr_breap,
    // downstream port to AXIMem
    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    output logic [ADDR_W-1:0]   m_ar_addr,
    output logic [2:0]          m_ar_prot,
    output logic                m_aw_valid,
    input  logic                m_aw_ready,
    output logic [ADDR_W-1:0]   m_aw_addr,
    output logic [2:0]          m_aw_prot,
    output logic                m_wd_valid,
    input  logic                m_wd_ready,
    output logic [DATA_W-1:0]   m_wd_data,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_rd_valid,
    output logic                m_rd_ready,
    input  logic [DATA_W-1:0]   m_rd_data,
    input  logic                m_wr_valid,
    output logic                m_wr_ready,
    input  logic [1:0]          m_wr_breap
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    arb_state_e state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       drop_q, drop_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic       rr_q, rr_d;

    logic [1:0] s_ar_valid, s_aw_valid, s_wd_valid, s_rd_ready, s_wr_ready;
    logic [1:0] req;
    logic       win_idx, win_valid;
    logic       ar_hs, aw_hs, wd_hs, rd_hs, wr_hs;
    logic       aw_done_now, w_done_now;

    assign s_ar_valid = {s1_ar_valid, s0_ar_valid};
    assign s_aw_valid = {s1_aw_valid, s0_aw_valid};
    assign s_wd_valid = {s1_wd_valid, s0_wd_valid};
    assign s_rd_ready = {s1_rd_ready, s0_rd_ready};
    assign s_wr_ready = {s1_wr_ready, s0_wr_ready};

    // The instruction side may not start a new transaction while flushing.
    assign req[PORT_INST] = (s0_aw_valid | s0_ar_valid) & ~flush;
    assign req[PORT_DATA] = s1_aw_valid | s1_ar_valid;

    arb_pick #(.ROUND_ROBIN(RR_MODE)) u_pick (
        .req_i       (req),
        .ptr_i       (rr_q),
        .win_o       (win_idx),
        .win_valid_o (win_valid)
    );

    // Downstream channel mux, driven purely from registered state and grant.
    always_comb begin
        m_ar_valid = 1'b0;
        m_ar_addr  = '0;
        m_ar_prot  = '0;
        m_aw_valid = 1'b0;
        m_aw_addr  = '0;
        m_aw_prot  = '0;
        m_wd_valid = 1'b0;
        m_wd_data  = '0;
        m_wstrb    = '0;
        m_rd_ready = 1'b0;
        m_wr_ready = 1'b0;
        case (state_q)
            ST_AR: begin
                m_ar_valid = s_ar_valid[gnt_q];
                m_ar_addr  = gnt_q ? s1_ar_addr : s0_ar_addr;
                m_ar_prot  = gnt_q ? s1_ar_prot : s0_ar_prot;
            end
            ST_R: begin
                // A dropped read is drained by the arbiter itself.
                m_rd_ready = drop_q | s_rd_ready[gnt_q];
            end
            ST_W: begin
                m_aw_valid = s_aw_valid[gnt_q] & ~aw_done_q;
                m_aw_addr  = gnt_q ? s1_aw_addr : s0_aw_addr;
                m_aw_prot  = gnt_q ? s1_aw_prot : s0_aw_prot;
                m_wd_valid = s_wd_valid[gnt_q] & ~w_done_q;
                m_wd_data  = gnt_q ? s1_wd_data : s0_wd_data;
                m_wstrb    = gnt_q ? s1_wstrb : s0_wstrb;
            end
            ST_B: begin
                m_wr_ready = s_wr_ready[gnt_q];
            end
            default: ;
        endcase
    end

    assign ar_hs       = m_ar_valid & m_ar_ready;
    assign aw_hs       = m_aw_valid & m_aw_ready;
    assign wd_hs       = m_wd_valid & m_wd_ready;
    assign rd_hs       = m_rd_valid & m_rd_ready;
    assign wr_hs       = m_wr_valid & m_wr_ready;
    assign aw_done_now = aw_done_q | aw_hs;
    assign w_done_now  = w_done_q | wd_hs;

    // Upstream return paths: only the granted port sees ready/valid.
    logic                s_ar_ready_v [2];
    logic                s_aw_ready_v [2];
    logic                s_wd_ready_v [2];
    logic                s_rd_valid_v [2];
    logic [DATA_W-1:0]   s_rd_data_v  [2];
    logic                s_wr_valid_v [2];
    logic [1:0]          s_wr_breap_v [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic sel;
            assign sel              = (gnt_q == 1'(gi));
            assign s_ar_ready_v[gi] = sel && (state_q == ST_AR) && m_ar_ready;
            assign s_aw_ready_v[gi] = sel && (state_q == ST_W) && !aw_done_q && m_aw_ready;
            assign s_wd_ready_v[gi] = sel && (state_q == ST_W) && !w_done_q && m_wd_ready;
            assign s_rd_valid_v[gi] = sel && (state_q == ST_R) && !drop_q && m_rd_valid;
            assign s_rd_data_v[gi]  = (sel && (state_q == ST_R)) ? m_rd_data : '0;
            assign s_wr_valid_v[gi] = sel && (state_q == ST_B) && m_wr_valid;
            assign s_wr_breap_v[gi] = (sel && (state_q == ST_B)) ? m_wr_breap : BRESP_OKAY;
        end
    endgenerate

    assign s0_ar_ready = s_ar_ready_v[0];
    assign s0_aw_ready = s_aw_ready_v[0];
    assign s0_wd_ready = s_wd_ready_v[0];
    assign s0_rd_valid = s_rd_valid_v[0];
    assign s0_rd_data  = s_rd_data_v[0];
    assign s0_wr_valid = s_wr_valid_v[0];
    assign s0_wr_breap = s_wr_breap_v[0];
    assign s1_ar_ready = s_ar_ready_v[1];
    assign s1_aw_ready = s_aw_ready_v[1];
    assign s1_wd_ready = s_wd_ready_v[1];
    assign s1_rd_valid = s_rd_valid_v[1];
    assign s1_rd_data  = s_rd_data_v[1];
    assign s1_wr_valid = s_wr_valid_v[1];
    assign s1_wr_breap = s_wr_breap_v[1];

    // Next-state: arbitrate in IDLE, then walk the address/data/response phases.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        drop_d    = drop_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rr_d      = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    gnt_d     = win_idx;
                    drop_d    = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    // A pending write on the winning port goes before its read.
                    state_d   = s_aw_valid[win_idx] ? ST_W : ST_AR;
                    if (RR_MODE) begin
                        rr_d = win_idx;
                    end
                end
            end
            ST_AR: begin
                if (flush && (gnt_q == PORT_INST)) begin
                    drop_d = 1'b1;
                end
                if (ar_hs) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (flush && (gnt_q == PORT_INST)) begin
                    drop_d = 1'b1;
                end
                if (rd_hs) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end
            end
            ST_W: begin
                aw_done_d = aw_done_now;
                w_done_d  = w_done_now;
                if (aw_done_now && w_done_now) begin
                    state_d   = ST_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_B: begin
                if (wr_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, grant and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= PORT_INST;
            drop_q    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            drop_q    <= drop_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rr_q      <= rr_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed, table-driven bench for axi_lite_arbiter. Each step drives one
// cycle of inputs (as a bit mask) and compares all valid/ready outputs,
// plus the routed address/data fields where a valid is expected.
module tb_axi_lite_arbiter;

    // input mask bits
    localparam logic [15:0] FLUSH  = 16'h0001;
    localparam logic [15:0] S0_ARV = 16'h0002;
    localparam logic [15:0] S0_AWV = 16'h0004;
    localparam logic [15:0] S0_WDV = 16'h0008;
    localparam logic [15:0] S0_RDR = 16'h0010;
    localparam logic [15:0] S0_WRR = 16'h0020;
    localparam logic [15:0] S1_ARV = 16'h0040;
    localparam logic [15:0] S1_AWV = 16'h0080;
    localparam logic [15:0] S1_WDV = 16'h0100;
    localparam logic [15:0] S1_RDR = 16'h0200;
    localparam logic [15:0] S1_WRR = 16'h0400;
    localparam logic [15:0] M_ARR  = 16'h0800;
    localparam logic [15:0] M_AWR  = 16'h1000;
    localparam logic [15:0] M_WDR  = 16'h2000;
    localparam logic [15:0] M_RDV  = 16'h4000;
    localparam logic [15:0] M_WRV  = 16'h8000;
    localparam logic [15:0] BOTH   = S0_ARV | S1_AWV | S1_WDV;

    // expected output mask bits
    localparam logic [14:0] O_M_ARV  = 15'h0001;
    localparam logic [14:0] O_M_AWV  = 15'h0002;
    localparam logic [14:0] O_M_WDV  = 15'h0004;
    localparam logic [14:0] O_M_RDR  = 15'h0008;
    localparam logic [14:0] O_M_WRR  = 15'h0010;
    localparam logic [14:0] O_S0_ARR = 15'h0020;
    localparam logic [14:0] O_S0_AWR = 15'h0040;
    localparam logic [14:0] O_S0_WDR = 15'h0080;
    localparam logic [14:0] O_S0_RDV = 15'h0100;
    localparam logic [14:0] O_S0_WRV = 15'h0200;
    localparam logic [14:0] O_S1_ARR = 15'h0400;
    localparam logic [14:0] O_S1_AWR = 15'h0800;
    localparam logic [14:0] O_S1_WDR = 15'h1000;
    localparam logic [14:0] O_S1_RDV = 15'h2000;
    localparam logic [14:0] O_S1_WRV = 15'h4000;
    localparam logic [14:0] NONE     = 15'h0000;

    localparam logic [31:0] A0R = 32'h1c000000;
    localparam logic [31:0] A0W = 32'h1c000040;
    localparam logic [31:0] A1R = 32'h1c000080;
    localparam logic [31:0] A1W = 32'h1c000100;
    localparam logic [31:0] D0  = 32'hA5A5A5A5;
    localparam logic [31:0] D1  = 32'h12345678;
    localparam logic [31:0] RD  = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset;
    logic [15:0] in_v;
    logic [14:0] out_v;

    logic flush;
    logic s0_ar_valid, s0_ar_ready, s0_aw_valid, s0_aw_ready, s0_wd_valid, s0_wd_ready;
    logic s0_rd_valid, s0_rd_ready, s0_wr_valid, s0_wr_ready;
    logic s1_ar_valid, s1_ar_ready, s1_aw_valid, s1_aw_ready, s1_wd_valid, s1_wd_ready;
    logic s1_rd_valid, s1_rd_ready, s1_wr_valid, s1_wr_ready;
    logic m_ar_valid, m_ar_ready, m_aw_valid, m_aw_ready, m_wd_valid, m_wd_ready;
    logic m_rd_valid, m_rd_ready, m_wr_valid, m_wr_ready;
    logic [31:0] s0_rd_data, s1_rd_data, m_ar_addr, m_aw_addr, m_wd_data;
    logic [3:0]  m_wstrb;
    logic [2:0]  m_ar_prot, m_aw_prot;
    logic [1:0]  s0_wr_breap, s1_wr_breap;

    int checks = 0;
    int errors = 0;

    assign flush       = in_v[0];
    assign s0_ar_valid = in_v[1];
    assign s0_aw_valid = in_v[2];
    assign s0_wd_valid = in_v[3];
    assign s0_rd_ready = in_v[4];
    assign s0_wr_ready = in_v[5];
    assign s1_ar_valid = in_v[6];
    assign s1_aw_valid = in_v[7];
    assign s1_wd_valid = in_v[8];
    assign s1_rd_ready = in_v[9];
    assign s1_wr_ready = in_v[10];
    assign m_ar_ready  = in_v[11];
    assign m_aw_ready  = in_v[12];
    assign m_wd_ready  = in_v[13];
    assign m_rd_valid  = in_v[14];
    assign m_wr_valid  = in_v[15];

    assign out_v = {s1_wr_valid, s1_rd_valid, s1_wd_ready, s1_aw_ready, s1_ar_ready,
                    s0_wr_valid, s0_rd_valid, s0_wd_ready, s0_aw_ready, s0_ar_ready,
                    m_wr_ready, m_rd_ready, m_wd_valid, m_aw_valid, m_ar_valid};

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s0_ar_valid(s0_ar_valid), .s0_ar_ready(s0_ar_ready), .s0_ar_addr(A0R), .s0_ar_prot(3'd1),
        .s0_aw_valid(s0_aw_valid), .s0_aw_ready(s0_aw_ready), .s0_aw_addr(A0W), .s0_aw_prot(3'd1),
        .s0_wd_valid(s0_wd_valid), .s0_wd_ready(s0_wd_ready), .s0_wd_data(D0), .s0_wstrb(4'h3),
        .s0_rd_valid(s0_rd_valid), .s0_rd_ready(s0_rd_ready), .s0_rd_data(s0_rd_data),
        .s0_wr_valid(s0_wr_valid), .s0_wr_ready(s0_wr_ready), .s0_wr_breap(s0_wr_breap),
        .s1_ar_valid(s1_ar_valid), .s1_ar_ready(s1_ar_ready), .s1_ar_addr(A1R), .s1_ar_prot(3'd2),
        .s1_aw_valid(s1_aw_valid), .s1_aw_ready(s1_aw_ready), .s1_aw_addr(A1W), .s1_aw_prot(3'd2),
        .s1_wd_valid(s1_wd_valid), .s1_wd_ready(s1_wd_ready), .s1_wd_data(D1), .s1_wstrb(4'hF),
        .s1_rd_valid(s1_rd_valid), .s1_rd_ready(s1_rd_ready), .s1_rd_data(s1_rd_data),
        .s1_wr_valid(s1_wr_valid), .s1_wr_ready(s1_wr_ready), .s1_wr_breap(s1_wr_breap),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot),
        .m_wd_valid(m_wd_valid), .m_wd_ready(m_wd_ready), .m_wd_data(m_wd_data), .m_wstrb(m_wstrb),
        .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_data(RD),
        .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready), .m_wr_breap(2'b00)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // One cycle: drive inputs just after the edge, compare at the falling edge.
    task automatic step(input string nm, input logic [15:0] iv, input logic [14:0] ev,
                        input logic gp);
        @(posedge clk);
        #1;
        in_v = iv;
        #4;
        checks++;
        if (out_v !== ev) begin
            errors++;
            $display("FAIL %s: handshakes got %h want %h (in %h)", nm, out_v, ev, iv);
        end else begin
            $display("ok   %s: in %h handshakes %h", nm, iv, out_v);
        end
        if (ev == NONE)
            chk32({nm, "/idle_data"},
                  m_ar_addr | m_aw_addr | m_wd_data | s0_rd_data | s1_rd_data |
                  {23'd0, m_wstrb, m_ar_prot, s0_wr_breap} | {30'd0, s1_wr_breap}, 32'd0);
        if ((ev & O_M_ARV) != 0) chk32({nm, "/ar_addr"}, m_ar_addr, gp ? A1R : A0R);
        if ((ev & O_M_AWV) != 0) chk32({nm, "/aw_addr"}, m_aw_addr, gp ? A1W : A0W);
        if ((ev & O_M_WDV) != 0) chk32({nm, "/wd_data"}, m_wd_data ^ {28'd0, m_wstrb},
                                       gp ? (D1 ^ 32'hF) : (D0 ^ 32'h3));
        if ((ev & O_S0_RDV) != 0) chk32({nm, "/s0_rd_data"}, s0_rd_data, RD);
        if ((ev & O_S1_WRV) != 0) chk32({nm, "/s1_breap"}, {30'd0, s1_wr_breap}, 32'd0);
    endtask

    // Both ports request in the same IDLE cycle; w is the expected winner.
    task automatic tie_round(input int r, input logic w);
        step($sformatf("tie%0d_idle", r), BOTH, NONE, 1'b0);
        if (w) begin
            step($sformatf("tie%0d_w", r), BOTH | M_AWR | M_WDR,
                 O_M_AWV | O_M_WDV | O_S1_AWR | O_S1_WDR, 1'b1);
            step($sformatf("tie%0d_b", r), S1_WRR | M_WRV, O_M_WRR | O_S1_WRV, 1'b1);
        end else begin
            step($sformatf("tie%0d_ar", r), BOTH | M_ARR | S0_RDR, O_M_ARV | O_S0_ARR, 1'b0);
            step($sformatf("tie%0d_r", r), S0_RDR | M_RDV, O_M_RDR | O_S0_RDV, 1'b0);
        end
        step($sformatf("tie%0d_done", r), 16'h0, NONE, 1'b0);
    endtask

    typedef struct {
        string       name;
        logic [15:0] in;
        logic [14:0] exp;
        logic        gp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_v  = 16'h0;

        // s0 read alone, slave answers after two wait cycles
        tbl.push_back('{"rd0_idle",  S0_ARV | S0_RDR,          NONE,                 1'b0});
        tbl.push_back('{"rd0_ar",    S0_ARV | S0_RDR | M_ARR,  O_M_ARV | O_S0_ARR,   1'b0});
        tbl.push_back('{"rd0_wait1", S0_RDR,                   O_M_RDR,              1'b0});
        tbl.push_back('{"rd0_wait2", S0_RDR,                   O_M_RDR,              1'b0});
        tbl.push_back('{"rd0_beat",  S0_RDR | M_RDV,           O_M_RDR | O_S0_RDV,   1'b0});
        tbl.push_back('{"rd0_done",  16'h0,                    NONE,                 1'b0});
        // s0 read vs s1 write in the same cycle: write first, then read
        tbl.push_back('{"mix_idle",  BOTH,                     NONE,                 1'b1});
        tbl.push_back('{"mix_w",     BOTH | M_AWR | M_WDR,
                        O_M_AWV | O_M_WDV | O_S1_AWR | O_S1_WDR,                     1'b1});
        tbl.push_back('{"mix_b",     S0_ARV | S1_WRR | M_WRV,  O_M_WRR | O_S1_WRV,   1'b1});
        tbl.push_back('{"mix_idle2", S0_ARV,                   NONE,                 1'b0});
        tbl.push_back('{"mix_ar",    S0_ARV | M_ARR | S0_RDR,  O_M_ARV | O_S0_ARR,   1'b0});
        tbl.push_back('{"mix_r",     S0_RDR | M_RDV,           O_M_RDR | O_S0_RDV,   1'b0});
        tbl.push_back('{"mix_done",  16'h0,                    NONE,                 1'b0});
        // flush while s0 waits in R: beat consumed by the arbiter, hidden from s0
        tbl.push_back('{"fl_idle",   S0_ARV | S0_RDR,          NONE,                 1'b0});
        tbl.push_back('{"fl_ar",     S0_ARV | S0_RDR | M_ARR,  O_M_ARV | O_S0_ARR,   1'b0});
        tbl.push_back('{"fl_pulse",  FLUSH | S0_RDR,           O_M_RDR,              1'b0});
        tbl.push_back('{"fl_drain",  16'h0,                    O_M_RDR,              1'b0});
        tbl.push_back('{"fl_beat",   M_RDV,                    O_M_RDR,              1'b0});
        tbl.push_back('{"fl_idle2",  S0_ARV | S0_RDR,          NONE,                 1'b0});
        tbl.push_back('{"fl_ar2",    S0_ARV | S0_RDR | M_ARR,  O_M_ARV | O_S0_ARR,   1'b0});
        tbl.push_back('{"fl_beat2",  S0_RDR | M_RDV,           O_M_RDR | O_S0_RDV,   1'b0});
        // flush masks an s0 request in IDLE
        tbl.push_back('{"fm_masked", FLUSH | S0_ARV,           NONE,                 1'b0});
        tbl.push_back('{"fm_idle",   S0_ARV,                   NONE,                 1'b0});
        tbl.push_back('{"fm_ar",     S0_ARV | M_ARR | S0_RDR,  O_M_ARV | O_S0_ARR,   1'b0});
        tbl.push_back('{"fm_r",      S0_RDR | M_RDV,           O_M_RDR | O_S0_RDV,   1'b0});
        tbl.push_back('{"fm_done",   16'h0,                    NONE,                 1'b0});
        // slave takes wd two cycles before aw
        tbl.push_back('{"wf_idle",   S1_AWV | S1_WDV,          NONE,                 1'b1});
        tbl.push_back('{"wf_wd",     S1_AWV | S1_WDV | M_WDR,  O_M_AWV | O_M_WDV | O_S1_WDR, 1'b1});
        tbl.push_back('{"wf_gap1",   S1_AWV | M_WDR,           O_M_AWV,              1'b1});
        tbl.push_back('{"wf_gap2",   S1_AWV | M_WDR,           O_M_AWV,              1'b1});
        tbl.push_back('{"wf_aw",     S1_AWV | M_AWR,           O_M_AWV | O_S1_AWR,   1'b1});
        tbl.push_back('{"wf_b",      S1_WRR | M_WRV,           O_M_WRR | O_S1_WRV,   1'b1});
        tbl.push_back('{"wf_done",   16'h0,                    NONE,                 1'b0});
        // s0 write beats its own read; flush does not disturb a write
        tbl.push_back('{"w0_idle",   S0_ARV | S0_AWV | S0_WDV, NONE,                 1'b0});
        tbl.push_back('{"w0_w",      FLUSH | S0_ARV | S0_AWV | S0_WDV | M_AWR | M_WDR,
                        O_M_AWV | O_M_WDV | O_S0_AWR | O_S0_WDR,                     1'b0});
        tbl.push_back('{"w0_b",      S0_ARV | S0_WRR | M_WRV,  O_M_WRR | O_S0_WRV,   1'b0});
        tbl.push_back('{"w0_idle2",  S0_ARV | S0_RDR,          NONE,                 1'b0});
        tbl.push_back('{"w0_ar",     S0_ARV | S0_RDR | M_ARR,  O_M_ARV | O_S0_ARR,   1'b0});
        tbl.push_back('{"w0_r",      S0_RDR | M_RDV,           O_M_RDR | O_S0_RDV,   1'b0});
        tbl.push_back('{"w0_done",   16'h0,                    NONE,                 1'b0});

        // reset state, checked while reset is still held
        step("reset", M_RDV | M_WRV | M_ARR, NONE, 1'b0);
        step("reset2", 16'h0, NONE, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].name, tbl[i].in, tbl[i].exp, tbl[i].gp);
        end

        // repeated ties: last grant above was s0
        for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
            tie_round(r, (r % 2) == 0);
`else
            tie_round(r, 1'b1);
`endif
        end

        // reset while in AR
        step("rst_idle", S0_ARV, NONE, 1'b0);
        step("rst_in_ar", S0_ARV, O_M_ARV, 1'b0);
        reset = 1'b1;
        step("rst_after", M_ARR | M_AWR | M_WDR | M_RDV | M_WRV | S0_RDR | S0_WRR | S1_RDR | S1_WRR,
             NONE, 1'b0);
        reset = 1'b0;
        step("rst_regrant", S0_ARV | S0_RDR, NONE, 1'b0);
        step("rst_ar", S0_ARV | S0_RDR | M_ARR, O_M_ARV | O_S0_ARR, 1'b0);
        step("rst_r", S0_RDR | M_RDV, O_M_RDR | O_S0_RDV, 1'b0);
        step("rst_done", 16'h0, NONE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
